nn_op_sequencer: RTL and testbench
==================================

Name: nn_op_sequencer

Overview:
- Sequences the neural-net memory controller by driving its learn and classify level inputs for exact, parameterised cycle counts.
- Arbitrates between two requesters, a learn requester and a classify requester, over a req/ack handshake.
- Guarantees idle cycles between operations so the controller's internal read/write counters restart at 0.
- Sits between the host/test sequencer and the controller; its learn/classify outputs connect directly to the controller inputs.

Parameters:
- LEARN_CYCLES, 4: cycles learn is held high per learn operation (one per kernel/weight address pair).
- CLASSIFY_CYCLES, 4: cycles classify is held high per classify operation.
- GAP_CYCLES, 1: idle cycles forced after every operation; legal range is 1 or more.
- MAX_LEARN_STREAK, 2: consecutive learn grants allowed while classify is pending; legal range is 1 or more.
- COUNT_W, 16: width of the operation statistics counters.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- learn_req  in  1  level; held until learn_ack is seen.
- classify_req  in  1  level; held until classify_ack is seen.
- learn_ack  out  1  one-cycle pulse in the first cycle of a granted learn operation.
- classify_ack  out  1  one-cycle pulse in the first cycle of a granted classify operation.
- learn  out  1  to controller learn input.
- classify  out  1  to controller classify input.
- busy  out  1  high whenever the state is not IDLE.
- learn_done  out  1  one-cycle pulse in the cycle after the last learn cycle.
- classify_done  out  1  one-cycle pulse in the cycle after the last classify cycle.
- learn_count  out  COUNT_W  completed learn operations, saturating.
- classify_count  out  COUNT_W  completed classify operations, saturating.

Behaviour:
- Reset: rst is asynchronous. On assertion:
  - state goes to IDLE;
  - all outputs go to 0;
  - duration, gap and streak counters clear.
- Reset mid-operation: learn/classify drop immediately, no done pulse is generated, and counts clear.
- States:
  - IDLE: waiting for a request.
  - LEARN: learn=1 for LEARN_CYCLES cycles.
  - CLASSIFY: classify=1 for CLASSIFY_CYCLES cycles.
  - GAP: learn=0 and classify=0 for GAP_CYCLES cycles.
- Output timing: learn and classify are pure decodes of the registered state, and are never high together.
- Arbitration point: every IDLE cycle, and the last GAP cycle (gap_cnt == GAP_CYCLES-1). Requests are ignored in all other cycles.
- Grant rules at an arbitration point:
  - Only one request high: grant it.
  - Both high: grant learn unless learn_streak == MAX_LEARN_STREAK, in which case grant classify.
  - Neither high: enter or stay in IDLE.
- Streak counter: increments on each learn grant and saturates at MAX_LEARN_STREAK; clears on a classify grant.
- Grant timing: the next edge enters the op state with dur_cnt=0, and the matching ack is high in that first op cycle.
- Requester obligation: drop req at the edge ending the ack cycle. A req still high at the next arbitration point is treated as a new request.
- Op duration: dur_cnt increments each cycle. When dur_cnt == N-1 the next edge enters GAP with gap_cnt=0; the done pulse and count increment occur in that first GAP cycle.
- Gap exit: at the last GAP cycle the FSM goes to an op state if a grant is made, otherwise to IDLE.
- Spacing: minimum spacing between operations is exactly GAP_CYCLES low cycles on both learn and classify.
- Request changes during an op or GAP (rise or fall outside an arbitration point) have no effect until the next arbitration point.
- Counters:
  - learn_count and classify_count saturate at 2^COUNT_W-1.
  - dur_cnt width is $clog2(max(LEARN_CYCLES, CLASSIFY_CYCLES)+1).
  - Illegal parameter values trigger an elaboration-time $error.

Decomposition:
- Package nn_seq_pkg holds:
  - the state enum typedef {IDLE, LEARN, CLASSIFY, GAP};
  - the op typedef {OP_NONE, OP_LEARN, OP_CLASSIFY};
  - a function computing dur_cnt width.
- One natural sub-module: nn_seq_arb. It holds the streak counter and grant logic, takes both reqs plus an arbitration-point strobe, and returns an op_t grant.

Test Plan (default parameters unless stated):
- Reset: hold rst, then release with no requests -> all outputs 0, busy=0; asserting rst mid-LEARN drops learn in the same cycle and learn_count=0.
- Single learn: learn_req rises before edge 0 -> learn=1 in cycles 1-4, learn_ack in cycle 1, learn_done and learn_count=1 in cycle 5, busy=1 in cycles 1-5, busy=0 in cycle 6.
- Both reqs held continuously (requester re-raises after each ack) -> grant sequence L,L,C,L,L,C with exactly one idle cycle between consecutive operations, and classify never starved beyond 2 learns.
- Classify in progress, learn_req raised in cycle 2 of classify -> learn_ack appears exactly 2 cycles after the last classify cycle (one GAP cycle, then the op).
- GAP_CYCLES=3, LEARN_CYCLES=2: back-to-back learn reqs -> learn high for 2 cycles, low for 3, high for 2.
- COUNT_W=2: five single learn operations -> learn_count sequence 1,2,3,3,3 and five learn_done pulses.

Source files
------------

// File: rtl/nn_seq_pkg.sv
// Shared types and helpers for the neural-net operation sequencer.
package nn_seq_pkg;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LEARN    = 2'd1,
        CLASSIFY = 2'd2,
        GAP      = 2'd3
    } state_t;

    // Arbitration outcome
    typedef enum logic [1:0] {
        OP_NONE     = 2'd0,
        OP_LEARN    = 2'd1,
        OP_CLASSIFY = 2'd2
    } op_t;

    // Width of the duration counter: must hold the longer of the two op lengths
    function automatic int dur_cnt_width(input int learn_cycles, input int classify_cycles);
        int longest;
        longest = (learn_cycles > classify_cycles) ? learn_cycles : classify_cycles;
        return $clog2(longest + 1);
    endfunction

    // Width needed to hold values 0..max_value
    function automatic int value_width(input int max_value);
        return $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/nn_seq_arb.sv
// Learn/classify arbiter: learn wins ties until it has taken MAX_LEARN_STREAK
// grants in a row, after which a pending classify is served.
module nn_seq_arb
    import nn_seq_pkg::*;
#(
    parameter int MAX_LEARN_STREAK = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic arb_point,
    input  logic learn_req,
    input  logic classify_req,
    output op_t  grant
);

    localparam int STREAK_W = value_width(MAX_LEARN_STREAK);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_LEARN_STREAK);

    logic [STREAK_W-1:0] streak_r;
    op_t                 grant_s;

    // Pick the winner at an arbitration point; requests are ignored elsewhere
    always_comb begin
        grant_s = OP_NONE;
        if (arb_point) begin
            if (learn_req && classify_req) begin
                if (streak_r == STREAK_MAX) begin
                    grant_s = OP_CLASSIFY;
                end else begin
                    grant_s = OP_LEARN;
                end
            end else if (learn_req) begin
                grant_s = OP_LEARN;
            end else if (classify_req) begin
                grant_s = OP_CLASSIFY;
            end else begin
                grant_s = OP_NONE;
            end
        end else begin
            grant_s = OP_NONE;
        end
    end

    // Count consecutive learn grants (saturating); a classify grant restarts the count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak_r <= '0;
        end else begin
            case (grant_s)
                OP_LEARN: begin
                    if (streak_r != STREAK_MAX) begin
                        streak_r <= streak_r + 1'b1;
                    end else begin
                        streak_r <= streak_r;
                    end
                end
                OP_CLASSIFY: streak_r <= '0;
                default:     streak_r <= streak_r;
            endcase
        end
    end

    assign grant = grant_s;

endmodule

// File: rtl/nn_op_sequencer.sv
// Drives the controller's learn/classify levels for fixed cycle counts,
// arbitrates between the two requesters and forces idle gaps between
// operations so the controller's address counters restart at zero.
module nn_op_sequencer
    import nn_seq_pkg::*;
#(
    parameter int LEARN_CYCLES     = 4,
    parameter int CLASSIFY_CYCLES  = 4,
    parameter int GAP_CYCLES       = 1,
    parameter int MAX_LEARN_STREAK = 2,
    parameter int COUNT_W          = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               learn_req,
    input  logic               classify_req,
    output logic               learn_ack,
    output logic               classify_ack,
    output logic               learn,
    output logic               classify,
    output logic               busy,
    output logic               learn_done,
    output logic               classify_done,
    output logic [COUNT_W-1:0] learn_count,
    output logic [COUNT_W-1:0] classify_count
);

    localparam int DUR_W = dur_cnt_width(LEARN_CYCLES, CLASSIFY_CYCLES);
    localparam int GAP_W = value_width(GAP_CYCLES);
    localparam logic [DUR_W-1:0]   LEARN_LAST    = DUR_W'(LEARN_CYCLES - 1);
    localparam logic [DUR_W-1:0]   CLASSIFY_LAST = DUR_W'(CLASSIFY_CYCLES - 1);
    localparam logic [GAP_W-1:0]   GAP_LAST      = GAP_W'(GAP_CYCLES - 1);
    localparam logic [COUNT_W-1:0] COUNT_MAX     = '1;

    if (LEARN_CYCLES < 1) begin : g_bad_learn_cycles
        $error("nn_op_sequencer: LEARN_CYCLES must be >= 1");
    end
    if (CLASSIFY_CYCLES < 1) begin : g_bad_classify_cycles
        $error("nn_op_sequencer: CLASSIFY_CYCLES must be >= 1");
    end
    if (GAP_CYCLES < 1) begin : g_bad_gap_cycles
        $error("nn_op_sequencer: GAP_CYCLES must be >= 1");
    end
    if (MAX_LEARN_STREAK < 1) begin : g_bad_streak
        $error("nn_op_sequencer: MAX_LEARN_STREAK must be >= 1");
    end
    if (COUNT_W < 1) begin : g_bad_count_w
        $error("nn_op_sequencer: COUNT_W must be >= 1");
    end

    state_t             state_r;
    state_t             state_nxt;
    logic [DUR_W-1:0]   dur_cnt_r;
    logic [DUR_W-1:0]   dur_nxt;
    logic [GAP_W-1:0]   gap_cnt_r;
    logic [GAP_W-1:0]   gap_nxt;
    logic               learn_ack_r;
    logic               learn_ack_nxt;
    logic               classify_ack_r;
    logic               classify_ack_nxt;
    logic               learn_done_r;
    logic               learn_done_nxt;
    logic               classify_done_r;
    logic               classify_done_nxt;
    logic [COUNT_W-1:0] learn_count_r;
    logic [COUNT_W-1:0] classify_count_r;
    logic               arb_point_s;
    op_t                grant_s;

    nn_seq_arb #(
        .MAX_LEARN_STREAK (MAX_LEARN_STREAK)
    ) u_arb (
        .clk          (clk),
        .rst          (rst),
        .arb_point    (arb_point_s),
        .learn_req    (learn_req),
        .classify_req (classify_req),
        .grant        (grant_s)
    );

    // Arbitration happens in every IDLE cycle and in the final GAP cycle only
    always_comb begin
        arb_point_s = 1'b0;
        case (state_r)
            IDLE:    arb_point_s = 1'b1;
            GAP:     arb_point_s = (gap_cnt_r == GAP_LAST);
            default: arb_point_s = 1'b0;
        endcase
    end

    // Next state, counters and one-cycle ack/done pulses
    always_comb begin
        state_nxt         = state_r;
        dur_nxt           = dur_cnt_r;
        gap_nxt           = gap_cnt_r;
        learn_ack_nxt     = 1'b0;
        classify_ack_nxt  = 1'b0;
        learn_done_nxt    = 1'b0;
        classify_done_nxt = 1'b0;
        case (state_r)
            IDLE, GAP: begin
                if (arb_point_s) begin
                    case (grant_s)
                        OP_LEARN: begin
                            state_nxt     = LEARN;
                            dur_nxt       = '0;
                            learn_ack_nxt = 1'b1;
                        end
                        OP_CLASSIFY: begin
                            state_nxt        = CLASSIFY;
                            dur_nxt          = '0;
                            classify_ack_nxt = 1'b1;
                        end
                        default: state_nxt = IDLE;
                    endcase
                end else begin
                    gap_nxt = gap_cnt_r + 1'b1;
                end
            end
            LEARN: begin
                if (dur_cnt_r == LEARN_LAST) begin
                    state_nxt      = GAP;
                    gap_nxt        = '0;
                    learn_done_nxt = 1'b1;
                end else begin
                    dur_nxt = dur_cnt_r + 1'b1;
                end
            end
            CLASSIFY: begin
                if (dur_cnt_r == CLASSIFY_LAST) begin
                    state_nxt         = GAP;
                    gap_nxt           = '0;
                    classify_done_nxt = 1'b1;
                end else begin
                    dur_nxt = dur_cnt_r + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, duration/gap counters and pulse registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r         <= IDLE;
            dur_cnt_r       <= '0;
            gap_cnt_r       <= '0;
            learn_ack_r     <= 1'b0;
            classify_ack_r  <= 1'b0;
            learn_done_r    <= 1'b0;
            classify_done_r <= 1'b0;
        end else begin
            state_r         <= state_nxt;
            dur_cnt_r       <= dur_nxt;
            gap_cnt_r       <= gap_nxt;
            learn_ack_r     <= learn_ack_nxt;
            classify_ack_r  <= classify_ack_nxt;
            learn_done_r    <= learn_done_nxt;
            classify_done_r <= classify_done_nxt;
        end
    end

    // Saturating completed-operation counters, stepped alongside the done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            learn_count_r    <= '0;
            classify_count_r <= '0;
        end else begin
            if (learn_done_nxt && (learn_count_r != COUNT_MAX)) begin
                learn_count_r <= learn_count_r + 1'b1;
            end else begin
                learn_count_r <= learn_count_r;
            end
            if (classify_done_nxt && (classify_count_r != COUNT_MAX)) begin
                classify_count_r <= classify_count_r + 1'b1;
            end else begin
                classify_count_r <= classify_count_r;
            end
        end
    end

    assign learn          = (state_r == LEARN);
    assign classify       = (state_r == CLASSIFY);
    assign busy           = (state_r != IDLE);
    assign learn_ack      = learn_ack_r;
    assign classify_ack   = classify_ack_r;
    assign learn_done     = learn_done_r;
    assign classify_done  = classify_done_r;
    assign learn_count    = learn_count_r;
    assign classify_count = classify_count_r;

endmodule

// File: tb/tb_nn_op_sequencer.sv
// Self-checking bench for nn_op_sequencer: directed scenarios plus a
// randomized run against a schedule-level reference model, on two instances
// (default parameters, and a short-op / long-gap / narrow-counter variant).
module tb_nn_op_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] lreq = 2'b00;
    logic [1:0] creq = 2'b00;

    int tests_run    = 0;
    int tests_failed = 0;

    // Per-instance parameters, mirrored for the reference model
    int P_L[2]    = '{4, 2};
    int P_C[2]    = '{4, 3};
    int P_G[2]    = '{1, 3};
    int P_M[2]    = '{2, 1};
    int P_CMAX[2] = '{65535, 3};

    logic        l0, c0, la0, ca0, b0, ld0, cd0;
    logic [15:0] lc0, cc0;
    logic        l1, c1, la1, ca1, b1, ld1, cd1;
    logic [1:0]  lc1, cc1;

    always #5 clk = ~clk;

    nn_op_sequencer u_dut0 (
        .clk(clk), .rst(rst), .learn_req(lreq[0]), .classify_req(creq[0]),
        .learn_ack(la0), .classify_ack(ca0), .learn(l0), .classify(c0), .busy(b0),
        .learn_done(ld0), .classify_done(cd0), .learn_count(lc0), .classify_count(cc0)
    );

    nn_op_sequencer #(
        .LEARN_CYCLES(2), .CLASSIFY_CYCLES(3), .GAP_CYCLES(3), .MAX_LEARN_STREAK(1), .COUNT_W(2)
    ) u_dut1 (
        .clk(clk), .rst(rst), .learn_req(lreq[1]), .classify_req(creq[1]),
        .learn_ack(la1), .classify_ack(ca1), .learn(l1), .classify(c1), .busy(b1),
        .learn_done(ld1), .classify_done(cd1), .learn_count(lc1), .classify_count(cc1)
    );

    // {learn, classify, learn_ack, classify_ack, busy, learn_done, classify_done}
    function automatic logic [6:0] flags(input int i);
        if (i == 0) return {l0, c0, la0, ca0, b0, ld0, cd0};
        else        return {l1, c1, la1, ca1, b1, ld1, cd1};
    endfunction

    function automatic logic [15:0] lcnt(input int i);
        if (i == 0) return lc0;
        else        return {14'd0, lc1};
    endfunction

    function automatic logic [15:0] ccnt(input int i);
        if (i == 0) return cc0;
        else        return {14'd0, cc1};
    endfunction

    // Leaves the bench at a falling edge with rst just released: that cycle is cycle 0
    task automatic apply_reset();
        @(negedge clk);
        rst  = 1'b1;
        lreq = 2'b00;
        creq = 2'b00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 2; i++) begin
                tests_run++;
                if (flags(i) !== 7'b0) begin
                    tests_failed++;
                    $display("FAIL reset dut%0d c=%0d flags got %b expected 0000000", i, c, flags(i));
                end
                tests_run++;
                if (lcnt(i) !== 16'd0 || ccnt(i) !== 16'd0) begin
                    tests_failed++;
                    $display("FAIL reset_counts dut%0d got %0d/%0d expected 0/0", i, lcnt(i), ccnt(i));
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_single_learn();
        logic [6:0] exp;
        apply_reset();
        for (int c = 0; c < 8; c++) begin
            exp = {(c >= 1 && c <= 4), 1'b0, (c == 1), 1'b0, (c >= 1 && c <= 5), (c == 5), 1'b0};
            tests_run++;
            if (flags(0) !== exp) begin
                tests_failed++;
                $display("FAIL single_learn c=%0d flags got %b expected %b", c, flags(0), exp);
            end
            tests_run++;
            if (lcnt(0) !== ((c >= 5) ? 16'd1 : 16'd0)) begin
                tests_failed++;
                $display("FAIL single_learn_count c=%0d got %0d expected %0d", c, lcnt(0), (c >= 5) ? 1 : 0);
            end
            if (c == 0) lreq[0] = 1'b1;
            else if (c == 2) lreq[0] = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_both_held();
        logic [6:0] exp, obs;
        int k, ph, ty;
        logic prev_la, prev_ca;
        prev_la = 1'b0;
        prev_ca = 1'b0;
        apply_reset();
        for (int c = 0; c < 32; c++) begin
            if (c >= 1) begin
                k  = (c - 1) / 5;
                ph = (c - 1) % 5;
                ty = (k % 3 == 2) ? 2 : 1;
            end else begin
                ph = -1;
                ty = 0;
            end
            exp = {(ph >= 0 && ph < 4 && ty == 1), (ph >= 0 && ph < 4 && ty == 2),
                   (ph == 0 && ty == 1), (ph == 0 && ty == 2), (c >= 1),
                   (ph == 4 && ty == 1), (ph == 4 && ty == 2)};
            obs = flags(0);
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL both_held c=%0d flags got %b expected %b", c, obs, exp);
            end
            if (c == 31) begin
                tests_run++;
                if (lcnt(0) !== 16'd4 || ccnt(0) !== 16'd2) begin
                    tests_failed++;
                    $display("FAIL both_held_counts got %0d/%0d expected 4/2", lcnt(0), ccnt(0));
                end
            end
            lreq[0] = ~prev_la;
            creq[0] = ~prev_ca;
            prev_la = obs[4];
            prev_ca = obs[3];
            @(negedge clk);
        end
    endtask

    task automatic test_classify_then_learn();
        logic [6:0] exp;
        apply_reset();
        for (int c = 0; c < 12; c++) begin
            exp = {(c >= 6 && c <= 9), (c >= 1 && c <= 4), (c == 6), (c == 1),
                   (c >= 1 && c <= 10), (c == 10), (c == 5)};
            tests_run++;
            if (flags(0) !== exp) begin
                tests_failed++;
                $display("FAIL classify_then_learn c=%0d flags got %b expected %b", c, flags(0), exp);
            end
            if (c == 0) creq[0] = 1'b1;
            else if (c == 2) begin
                creq[0] = 1'b0;
                lreq[0] = 1'b1;
            end else if (c == 7) lreq[0] = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_learn();
        apply_reset();
        for (int c = 0; c < 8; c++) begin
            if (c == 0 || c == 6) lreq[0] = 1'b1;
            else if (c == 2) lreq[0] = 1'b0;
            @(negedge clk);
        end
        lreq[0] = 1'b0;
        tests_run++;
        if (l0 !== 1'b1 || lc0 !== 16'd1) begin
            tests_failed++;
            $display("FAIL pre_reset learn/count got %b/%0d expected 1/1", l0, lc0);
        end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (flags(0) !== 7'b0 || lcnt(0) !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_mid_learn flags/count got %b/%0d expected 0000000/0", flags(0), lcnt(0));
        end
    endtask

    task automatic test_gap3();
        logic [6:0] exp, obs;
        int ph;
        logic prev_la;
        prev_la = 1'b0;
        apply_reset();
        for (int c = 0; c < 16; c++) begin
            ph  = (c >= 1) ? (c - 1) % 5 : -1;
            exp = {(ph >= 0 && ph < 2), 1'b0, (ph == 0), 1'b0, (c >= 1), (ph == 2), 1'b0};
            obs = flags(1);
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL gap3 c=%0d flags got %b expected %b", c, obs, exp);
            end
            lreq[1] = ~prev_la;
            prev_la = obs[4];
            @(negedge clk);
        end
    endtask

    task automatic test_count_sat();
        int ph, op, expc;
        apply_reset();
        for (int c = 0; c < 30; c++) begin
            ph   = c % 6;
            op   = c / 6;
            expc = op + ((ph >= 3) ? 1 : 0);
            if (expc > 3) expc = 3;
            tests_run++;
            if (lcnt(1) !== 16'(expc) || ld1 !== (ph == 3)) begin
                tests_failed++;
                $display("FAIL count_sat c=%0d count/done got %0d/%b expected %0d/%b",
                         c, lcnt(1), ld1, expc, (ph == 3));
            end
            lreq[1] = (ph == 0 || ph == 1);
            @(negedge clk);
        end
    endtask

    // Reference model: tracks the scheduled operation window (start, length,
    // type), the next arbitration cycle and the learn streak.
    task automatic test_random(input int i, input int ncyc);
        int arb_cyc, st, ty, n, streak, lc, cc, g;
        bit lr, cr, gl, in_op;
        logic [6:0] exp;
        apply_reset();
        arb_cyc = 0; st = -1; ty = 0; n = 0; streak = 0; lc = 0; cc = 0;
        lr = 1'b0; cr = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            in_op = (st >= 0) && (c >= st) && (c < st + n);
            if (st >= 0 && c == st + n) begin
                if (ty == 1) lc = (lc < P_CMAX[i]) ? lc + 1 : lc;
                else         cc = (cc < P_CMAX[i]) ? cc + 1 : cc;
            end
            exp = {(in_op && ty == 1), (in_op && ty == 2), (c == st && ty == 1), (c == st && ty == 2),
                   (st >= 0 && c >= st && c <= st + n + P_G[i] - 1),
                   (st >= 0 && c == st + n && ty == 1), (st >= 0 && c == st + n && ty == 2)};
            tests_run++;
            if (flags(i) !== exp) begin
                tests_failed++;
                $display("FAIL rand dut%0d c=%0d flags got %b expected %b", i, c, flags(i), exp);
            end
            tests_run++;
            if (lcnt(i) !== 16'(lc) || ccnt(i) !== 16'(cc)) begin
                tests_failed++;
                $display("FAIL rand_counts dut%0d c=%0d got %0d/%0d expected %0d/%0d",
                         i, c, lcnt(i), ccnt(i), lc, cc);
            end
            if (st >= 0 && c == st + 1) begin
                if (ty == 1) lr = 1'b0;
                else         cr = 1'b0;
            end else begin
                if (!lr && $urandom_range(0, 3) == 0) lr = 1'b1;
                if (!cr && $urandom_range(0, 3) == 0) cr = 1'b1;
            end
            gl = in_op && !lr && ($urandom_range(0, 7) == 0);
            lreq[i] = lr | gl;
            creq[i] = cr;
            if (c == arb_cyc) begin
                if (lr && cr)  g = (streak == P_M[i]) ? 2 : 1;
                else if (lr)   g = 1;
                else if (cr)   g = 2;
                else           g = 0;
                if (g == 1 && streak < P_M[i]) streak++;
                if (g == 2) streak = 0;
                if (g != 0) begin
                    st      = c + 1;
                    ty      = g;
                    n       = (g == 1) ? P_L[i] : P_C[i];
                    arb_cyc = c + n + P_G[i];
                end else begin
                    arb_cyc = c + 1;
                end
            end
            @(negedge clk);
        end
        lreq[i] = 1'b0;
        creq[i] = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_learn();
        test_both_held();
        test_classify_then_learn();
        test_reset_mid_learn();
        test_gap3();
        test_count_sat();
        test_random(0, 400);
        test_random(1, 400);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
